opc6_busarb: RTL

Single-port memory arbiter and clock-enable sequencer for the opc6 CPU. It shares one synchronous RAM between the CPU bus and one DMA requester, and routes CPU `vio` cycles to a separate IO strobe. It stalls the CPU through `cpu_clken` until each of the CPU's bus cycles has completed. The block sits between the CPU core, the system RAM, the IO decode and the DMA/video engine.

---
 rtl/opc6_busarb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/opc6_busarb.sv
// Single-port RAM arbiter for the opc6 CPU and one DMA requester.
// It also routes CPU IO cycles to io_ce and stalls the CPU via cpu_clken until each bus cycle completes.
module opc6_busarb #(
    parameter int RDLAT = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cpu_vpa,
    input  logic        cpu_vda,
    input  logic        cpu_vio,
    input  logic        cpu_rnw,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_clken,
    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic [15:0] dma_address,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        io_ce,
    input  logic [15:0] io_rdata
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic       GNT_CPU = 1'b0;
    localparam logic       GNT_DMA = 1'b1;
    localparam logic [1:0] RDLAT_L = 2'(RDLAT);

    state_t      state_r;
    logic        last_grant_r;
    logic        owner_r;
    logic        io_r;
    logic        rd_r;
    logic [1:0]  cnt_r;
    logic        mem_ce_r;
    logic        mem_we_r;
    logic        io_ce_r;
    logic [15:0] mem_address_r;
    logic [15:0] mem_wdata_r;
    logic [15:0] cpu_din_r;
    logic [15:0] dma_rdata_r;
    logic        clken_r;
    logic        dma_ack_r;

    logic        cpu_bus_s;
    logic        cpu_io_s;
    logic        grant_cpu_s;
    logic        grant_dma_s;
    logic        arb_free_s;
    logic [15:0] rdata_s;

    assign cpu_bus_s = cpu_vpa | cpu_vda;
    assign cpu_io_s  = cpu_vda & cpu_vio;
    assign rdata_s   = io_r ? io_rdata : mem_rdata;

    // Arbitration: strict alternation under contention, otherwise whoever asks.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dma_s = 1'b0;
        if (cpu_bus_s && dma_req) begin
            if (last_grant_r == GNT_DMA) begin
                grant_cpu_s = 1'b1;
            end else begin
                grant_dma_s = 1'b1;
            end
        end else if (cpu_bus_s) begin
            grant_cpu_s = 1'b1;
        end else if (dma_req) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_cpu_s = 1'b0;
            grant_dma_s = 1'b0;
        end
    end

    // Internal CPU cycles run at full speed; the reset term keeps clken low while held in reset.
    assign arb_free_s = reset_b & (state_r == ST_ARB) & ~cpu_bus_s;

    assign cpu_clken   = clken_r | arb_free_s;
    assign dma_ack     = dma_ack_r;
    assign cpu_din     = cpu_din_r;
    assign dma_rdata   = dma_rdata_r;
    assign mem_ce      = mem_ce_r;
    assign mem_we      = mem_we_r;
    assign io_ce       = io_ce_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;

    // Bus cycle sequencer: ARB -> XFER -> (WAIT) -> DONE with registered strobes and completions.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r       <= ST_ARB;
            last_grant_r  <= GNT_DMA;
            owner_r       <= GNT_CPU;
            io_r          <= 1'b0;
            rd_r          <= 1'b0;
            cnt_r         <= 2'd0;
            mem_ce_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            io_ce_r       <= 1'b0;
            mem_address_r <= 16'h0000;
            mem_wdata_r   <= 16'h0000;
            cpu_din_r     <= 16'h0000;
            dma_rdata_r   <= 16'h0000;
            clken_r       <= 1'b0;
            dma_ack_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (grant_cpu_s) begin
                        owner_r       <= GNT_CPU;
                        last_grant_r  <= GNT_CPU;
                        io_r          <= cpu_io_s;
                        rd_r          <= cpu_rnw;
                        mem_address_r <= cpu_address;
                        mem_wdata_r   <= cpu_dout;
                        mem_we_r      <= ~cpu_rnw;
                        mem_ce_r      <= ~cpu_io_s;
                        io_ce_r       <= cpu_io_s;
                        state_r       <= ST_XFER;
                    end else if (grant_dma_s) begin
                        owner_r       <= GNT_DMA;
                        last_grant_r  <= GNT_DMA;
                        io_r          <= 1'b0;
                        rd_r          <= dma_rnw;
                        mem_address_r <= dma_address;
                        mem_wdata_r   <= dma_wdata;
                        mem_we_r      <= ~dma_rnw;
                        mem_ce_r      <= 1'b1;
                        io_ce_r       <= 1'b0;
                        state_r       <= ST_XFER;
                    end else begin
                        state_r       <= ST_ARB;
                    end
                end
                ST_XFER: begin
                    mem_ce_r <= 1'b0;
                    io_ce_r  <= 1'b0;
                    mem_we_r <= 1'b0;
                    if (rd_r) begin
                        cnt_r   <= io_r ? 2'd1 : RDLAT_L;
                        state_r <= ST_WAIT;
                    end else begin
                        clken_r   <= (owner_r == GNT_CPU);
                        dma_ack_r <= (owner_r == GNT_DMA);
                        state_r   <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 2'd1) begin
                        if (owner_r == GNT_CPU) begin
                            cpu_din_r <= rdata_s;
                        end else begin
                            dma_rdata_r <= rdata_s;
                        end
                        clken_r   <= (owner_r == GNT_CPU);
                        dma_ack_r <= (owner_r == GNT_DMA);
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_DONE: begin
                    clken_r   <= 1'b0;
                    dma_ack_r <= 1'b0;
                    state_r   <= ST_ARB;
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

endmodule
